// File: rtl/score_entry_pkg.sv
// Shared definitions for the decimal keypad entry block: state encoding,
// digit/value limits and datapath widths.
package score_entry_pkg;

   localparam int unsigned MAX_DIGITS  = 4;
   localparam int unsigned VALUE_MAX   = 8191;
   localparam int unsigned BCD_MAX     = 9;
   localparam int unsigned DIGIT_WIDTH = 4;
   localparam int unsigned ACC_WIDTH   = 14;
   localparam int unsigned COUNT_WIDTH = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ENTRY = 2'd1,
      ST_DONE  = 2'd2,
      ST_ERR   = 2'd3
   } state_t;

   // True when the nibble is a legal decimal digit.
   function automatic logic is_bcd(input logic [DIGIT_WIDTH-1:0] d);
      return d <= DIGIT_WIDTH'(BCD_MAX);
   endfunction

endpackage

// File: rtl/score_entry_times_ten_add.sv
// Shift-and-add decimal step: sum_c = acc*10 + d, without a multiplier.
module times_ten_add
   import score_entry_pkg::*;
(
   input  logic [ACC_WIDTH-1:0]   acc,
   input  logic [DIGIT_WIDTH-1:0] d,
   output logic [ACC_WIDTH-1:0]   sum_c
);

   assign sum_c = (acc << 3) + (acc << 1) + ACC_WIDTH'(d);

endmodule

// File: rtl/score_entry.sv
// Keypad decimal entry: accumulates MSB-first BCD digits into a binary value,
// with range checking, error latching and a one-cycle commit pulse.
module score_entry
   import score_entry_pkg::*;
#(
   parameter int unsigned MAX_DIGITS  = 4,
   parameter int unsigned VALUE_WIDTH = 13
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [DIGIT_WIDTH-1:0] digit,
   input  logic                   digit_valid,
   input  logic                   commit,
   input  logic                   cancel,
   output logic [VALUE_WIDTH-1:0] value,
   output logic                   valid,
   output logic                   error,
   output logic [COUNT_WIDTH-1:0] count
);

   localparam int unsigned VMAX = (1 << VALUE_WIDTH) - 1;

   state_t                 state, state_n;
   logic [ACC_WIDTH-1:0]   acc, acc_n;
   logic [COUNT_WIDTH-1:0] count_n;
   logic [VALUE_WIDTH-1:0] value_n;
   logic                   valid_n;

   logic [ACC_WIDTH-1:0]   base_acc;
   logic [COUNT_WIDTH-1:0] base_cnt;
   logic [ACC_WIDTH-1:0]   step_sum;
   logic [ACC_WIDTH-1:0]   work_acc;
   logic [COUNT_WIDTH-1:0] work_cnt;
   logic                   digit_ok;
   logic                   digit_bad;

   // A digit arriving after a commit starts a fresh entry.
   assign base_acc = (state == ST_DONE) ? '0 : acc;
   assign base_cnt = (state == ST_DONE) ? '0 : count;

   times_ten_add u_step (
      .acc   (base_acc),
      .d     (digit),
      .sum_c (step_sum)
   );

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         acc   <= '0;
         count <= '0;
         value <= '0;
         valid <= 1'b0;
         error <= 1'b0;
      end else begin
         state <= state_n;
         acc   <= acc_n;
         count <= count_n;
         value <= value_n;
         valid <= valid_n;
         error <= (state_n == ST_ERR);
      end
   end

   // Next state: cancel wins, then the digit, then a commit of the updated sum.
   always_comb begin
      state_n   = state;
      acc_n     = acc;
      count_n   = count;
      value_n   = value;
      valid_n   = 1'b0;
      work_acc  = base_acc;
      work_cnt  = base_cnt;
      digit_ok  = 1'b0;
      digit_bad = 1'b0;

      if (digit_valid) begin
         if (!is_bcd(digit) || base_cnt == COUNT_WIDTH'(MAX_DIGITS)) begin
            digit_bad = 1'b1;
         end else begin
            digit_ok = 1'b1;
            work_acc = step_sum;
            work_cnt = base_cnt + COUNT_WIDTH'(1);
         end
      end

      if (cancel) begin
         state_n = ST_IDLE;
         acc_n   = '0;
         count_n = '0;
      end else if (state != ST_ERR) begin
         if (digit_bad) begin
            state_n = ST_ERR;
         end else if (commit) begin
            if (state == ST_DONE && !digit_ok) begin
               valid_n = 1'b1;
            end else if (work_acc > ACC_WIDTH'(VMAX)) begin
               state_n = ST_ERR;
               acc_n   = work_acc;
               count_n = work_cnt;
            end else begin
               state_n = ST_DONE;
               value_n = VALUE_WIDTH'(work_acc);
               valid_n = 1'b1;
               acc_n   = '0;
               count_n = '0;
            end
         end else if (digit_ok) begin
            state_n = ST_ENTRY;
            acc_n   = work_acc;
            count_n = work_cnt;
         end
      end
   end

endmodule

// File: tb/tb_score_entry.sv
// Bench for score_entry: directed keypad sequences plus random strobes,
// checked every cycle against a digit-queue model of the entry rules.
module tb_score_entry;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  digit;
   logic        digit_valid;
   logic        commit;
   logic        cancel;
   logic [12:0] value;
   logic        valid;
   logic        error;
   logic [2:0]  count;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   // Model: digits typed so far, last committed value, flags.
   int digs[$];
   int m_value;
   bit m_valid;
   bit m_err;
   bit m_done;

   score_entry #(.MAX_DIGITS(4), .VALUE_WIDTH(13)) dut (
      .clk         (clk),
      .rst         (rst),
      .digit       (digit),
      .digit_valid (digit_valid),
      .commit      (commit),
      .cancel      (cancel),
      .value       (value),
      .valid       (valid),
      .error       (error),
      .count       (count)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int digits_value();
      int v = 0;
      foreach (digs[i]) v = v * 10 + digs[i];
      return v;
   endfunction

   task automatic model_step();
      bit ok = 1'b1;
      int v;
      m_valid = 1'b0;
      if (cancel) begin
         digs.delete();
         m_err  = 1'b0;
         m_done = 1'b0;
      end else if (!m_err) begin
         if (digit_valid) begin
            if (int'(digit) > 9 || digs.size() == 4) begin
               m_err = 1'b1;
               ok    = 1'b0;
            end else begin
               m_done = 1'b0;
               digs.push_back(int'(digit));
            end
         end
         if (ok && commit) begin
            v = digits_value();
            if (m_done) begin
               m_valid = 1'b1;
            end else if (v > 8191) begin
               m_err = 1'b1;
            end else begin
               m_value = v;
               m_valid = 1'b1;
               m_done  = 1'b1;
               digs.delete();
            end
         end
      end
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         digs.delete();
         m_value = 0;
         m_valid = 1'b0;
         m_err   = 1'b0;
         m_done  = 1'b0;
      end else begin
         model_step();
      end
   end

   // Cycle-by-cycle comparison against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("value", int'(value), m_value);
         check("valid", int'(valid), int'(m_valid));
         check("error", int'(error), int'(m_err));
         check("count", int'(count), digs.size());
      end
   end

   task automatic cyc(input logic dv, input logic [3:0] d, input logic cm, input logic cn);
      digit_valid = dv;
      digit       = d;
      commit      = cm;
      cancel      = cn;
      @(negedge clk);
   endtask

   task automatic key(input int d);
      cyc(1'b1, 4'(d), 1'b0, 1'b0);
   endtask

   initial begin
      logic       dv, cm, cn;
      logic [3:0] d;

      rst = 1'b1;
      digit = '0; digit_valid = 1'b0; commit = 1'b0; cancel = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk_en = 1'b1;
      check("rst_value", int'(value), 0);
      check("rst_valid", int'(valid), 0);
      check("rst_error", int'(error), 0);
      check("rst_count", int'(count), 0);

      // 1234
      key(1); key(2); key(3); key(4);
      check("c1234_count", int'(count), 4);
      cyc(0, 0, 1, 0);
      check("c1234_value", int'(value), 1234);
      check("c1234_valid", int'(valid), 1);
      check("c1234_count0", int'(count), 0);
      cyc(0, 0, 0, 0);
      check("c1234_valid_once", int'(valid), 0);

      // 9999 overflows on commit
      key(9); key(9); key(9); key(9);
      cyc(0, 0, 1, 0);
      check("ovf_error", int'(error), 1);
      check("ovf_value", int'(value), 1234);
      check("ovf_valid", int'(valid), 0);
      cyc(0, 0, 0, 1);
      check("ovf_cancel_err", int'(error), 0);
      check("ovf_cancel_cnt", int'(count), 0);

      // 8191 with commit on the last digit
      key(8); key(1); key(9);
      cyc(1, 4'd1, 1, 0);
      check("c8191_value", int'(value), 8191);
      check("c8191_valid", int'(valid), 1);
      cyc(0, 0, 0, 0);
      check("c8191_valid_once", int'(valid), 0);

      // bad digit, ignored commit, fifth digit
      cyc(1, 4'hA, 0, 0);
      check("bad_digit_err", int'(error), 1);
      cyc(0, 0, 1, 0);
      check("err_commit_valid", int'(valid), 0);
      check("err_commit_value", int'(value), 8191);
      cyc(0, 0, 0, 1);
      key(1); key(2); key(3); key(4); key(5);
      check("fifth_digit_err", int'(error), 1);
      cyc(0, 0, 0, 1);

      // async reset mid-entry
      key(5); key(6);
      #2 rst = 1'b1;
      #1;
      check("arst_value", int'(value), 0);
      check("arst_count", int'(count), 0);
      check("arst_error", int'(error), 0);
      check("arst_valid", int'(valid), 0);
      @(negedge clk);
      rst = 1'b0;
      cyc(0, 0, 1, 0);
      check("arst_commit_value", int'(value), 0);
      check("arst_commit_valid", int'(valid), 1);

      // 42, then a new digit keeps the old value
      key(4); key(2);
      cyc(0, 0, 1, 0);
      check("c42_value", int'(value), 42);
      key(7);
      check("after42_value", int'(value), 42);
      check("after42_count", int'(count), 1);
      cyc(0, 0, 1, 0);
      check("c7_value", int'(value), 7);
      cyc(0, 0, 1, 0);
      check("recommit_valid", int'(valid), 1);
      check("recommit_value", int'(value), 7);

      // random strobes
      for (int i = 0; i < 3000; i++) begin
         cn = (m_err ? ($urandom % 4 == 0) : ($urandom % 40 == 0));
         dv = ($urandom % 3 != 0);
         d  = ($urandom % 16 == 0) ? 4'(10 + $urandom % 6) : 4'($urandom % 10);
         cm = ($urandom % 5 == 0);
         cyc(dv, d, cm, cn);
      end
      cyc(0, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/score_entry.md
# score_entry

Sequential decimal-to-binary entry block: accepts a most-significant-first stream of BCD digits, one per handshake, and accumulates them into a 13-bit binary value. It is the input-side counterpart of the score display path. The game controller uses it to take a typed reaction threshold or target score from the digit keypad and switches, then compares that value in binary against the measured time.

## Interface
Parameters:
- MAX_DIGITS, 4, maximum digits accepted per entry.
- VALUE_WIDTH, 13, output width; the committed value is limited to 2^VALUE_WIDTH-1 = 8191.

Ports:
- Clock, input, 1: single system clock; everything updates on its rising edge.
- Reset, input, 1: asynchronous, active-high reset.
- Digit, input, 4: BCD digit; valid values are 0–9.
- DigitValid, input, 1: single-cycle strobe that presents Digit.
- Commit, input, 1: single-cycle strobe that finishes the entry.
- Cancel, input, 1: single-cycle strobe that abandons the entry and clears any error.
- Value, output, 13: last committed binary value; held between commits.
- Valid, output, 1: one-cycle pulse on the cycle after a successful commit.
- Error, output, 1: level signal; high while the block is in ERR.
- Count, output, 3: number of digits accumulated in the current entry (0..MAX_DIGITS).

## Operation
- States:
  - IDLE: no digits held; accumulator is 0.
  - ENTRY: at least one digit held.
  - DONE: a value has been committed.
  - ERR: error latched.
- Internal accumulator is 14 bits wide; the largest 4-digit input, 9999, fits.
- Input priority in every state: Cancel, then DigitValid, then Commit.
- Cancel, in any state: accumulator=0, Count=0, Error=0, state becomes IDLE. Value is unchanged.
- DigitValid in IDLE, ENTRY or DONE:
  - Digit>9 -> state becomes ERR.
  - Count==MAX_DIGITS (a fifth digit) -> state becomes ERR.
  - Otherwise accumulator = accumulator*10 + Digit, Count increments, state becomes ENTRY.
  - From DONE, the accumulator and Count are first treated as 0, so a new entry starts. Value is kept until the next commit.
- Commit in IDLE: Value=0, Valid pulses, state becomes DONE.
- Commit in ENTRY:
  - accumulator>8191 -> state becomes ERR; Value is unchanged.
  - Otherwise Value=accumulator[12:0], Valid pulses, state becomes DONE, accumulator and Count clear.
- Commit in DONE: Value is re-committed; Valid pulses again.
- DigitValid and Commit in the same cycle: the digit is accumulated first, and the commit checks and loads the updated sum in that same cycle. An invalid digit sends the block to ERR and the commit is dropped.
- In ERR, DigitValid and Commit are ignored. Only Cancel or Reset leaves ERR.
- Reset, asynchronous: state=IDLE, accumulator=0, Value=0, Valid=0, Error=0, Count=0.

## Timing
- One digit is absorbed per clock. Strobes may arrive back-to-back on consecutive cycles; there is no backpressure and no busy signal.
- Count, Error and the accumulator are registered, so they update on the edge that samples the strobe.
- Value is registered and updates on the commit edge.
- Valid is high for exactly the one cycle following the commit edge.
- Error rises on the edge that samples the offending strobe. It falls on the edge that samples Cancel.
- Latency from the commit strobe to Value/Valid is 1 cycle. The whole path is fully synchronous apart from Reset.
- Reset asserted mid-entry discards partial digits immediately. No Valid pulse is produced for them.

## Structure
- Shared package holds:
  - the state encoding (IDLE, ENTRY, DONE, ERR);
  - MAX_DIGITS=4, VALUE_MAX=8191, BCD_MAX=9.
- One combinational sub-module, times_ten_add: acc*10 + d computed as (acc<<3)+(acc<<1)+d, with 14-bit in/out.
- The FSM, range checks and output registers live in score_entry.

## Test plan
- Digits 1,2,3,4 on consecutive cycles, then Commit -> Value=1234 (13'h04D2), one-cycle Valid, Count=0, Error=0.
- Digits 9,9,9,9, then Commit -> Error=1, Value keeps its prior value, no Valid. Cancel -> Error=0, Count=0.
- Digits 8,1,9,1 with Commit strobed together with the final digit -> Value=8191, Valid pulses once.
- Digit 4'hA presented -> Error=1. A following Commit is ignored. A fifth digit after 1,2,3,4 also gives Error=1.
- Reset asserted mid-entry after digits 5,6 -> all outputs 0 immediately. Commit afterwards -> Value=0 with Valid.
- Commit 42, then digit 7 -> Value stays 42, Count=1. Commit -> Value=7.
